cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
Shares the single physical-memory cacheline adapter (256-bit line port) between the instruction cache and the data cache. Each cache's pmem-side port connects here, and one downstream port drives the cacheline adapter. A three-state FSM with round-robin priority serializes line fills and writebacks. Requests are latched at grant so the downstream request stays stable until the adapter responds.

Parameters:
s_offset, 5, byte-offset bits of a line; downstream address low s_offset bits forced to 0
s_line, 256, cacheline width in bits
s_addr, 32, address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (state cleared on rising clk edge while rst==0)
i_pmem_read  in  1  icache line-fill request
i_pmem_address  in  s_addr  icache line address
i_pmem_rdata  out  s_line  fill data to icache
i_pmem_resp  out  1  icache completion pulse
d_pmem_read  in  1  dcache line-fill request
d_pmem_write  in  1  dcache writeback request
d_pmem_address  in  s_addr  dcache line address
d_pmem_wdata  in  s_line  dcache writeback data
d_pmem_rdata  out  s_line  fill data to dcache
d_pmem_resp  out  1  dcache completion pulse
pmem_read  out  1  read to cacheline adapter
pmem_write  out  1  write to cacheline adapter
pmem_address  out  s_addr  line address to adapter
pmem_wdata  out  s_line  write data to adapter
pmem_rdata  in  s_line  read data from adapter
pmem_resp  in  1  adapter completion

Behaviour:
- States: IDLE, BUSY, DONE. Registers: state, owner (I/D), op_write, addr_q, wdata_q, last_grant.
- Reset (rst==0 at edge): state=IDLE, owner=I, op_write=0, addr_q=0, wdata_q=0, last_grant=I (so D wins first contention).
  - Reset outputs: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_pmem_resp=0, d_pmem_resp=0.
- Request detection: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
  - If d_pmem_read and d_pmem_write are both 1, the op is a write.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the side != last_grant.
  - On grant (same edge): state->BUSY; owner, last_grant <= granted side.
  - Latch addr_q <= {addr[31:s_offset], 0}; latch op_write and wdata_q (D only; for I, op_write=0).
  - All pmem outputs are 0 while in IDLE.
- BUSY:
  - pmem_read = ~op_write; pmem_write = op_write; pmem_address = addr_q; pmem_wdata = wdata_q.
  - Requester inputs are ignored, including changes mid-transaction.
  - On pmem_resp==1: assert the owner's *_pmem_resp combinationally in the same cycle (non-owner resp stays 0); state->DONE.
  - pmem_read/pmem_write stay asserted through the resp cycle.
- DONE:
  - One-cycle gap; all pmem outputs and both resps are 0.
  - The requester drops its request here; state->IDLE unconditionally.
- rdata: i_pmem_rdata = d_pmem_rdata = pmem_rdata (broadcast, unregistered). Only meaningful in the owner's resp cycle.
- Latency: request seen in IDLE at cycle 0 -> pmem op asserted cycle 1 -> owner resp in the same cycle as pmem_resp.
  - Minimum turnaround between grants: resp cycle + DONE + IDLE sample.
- pmem_resp outside BUSY is ignored; no resp is forwarded.
- Reset mid-transaction: abandon immediately (state=IDLE, outputs 0). No resp is issued for the abandoned op.
- Starvation bound: with both caches continuously requesting, grants strictly alternate I/D.

Test Plan:
- Reset: hold rst=0 for 2 cycles with d_pmem_write=1 -> all outputs 0, state IDLE; release -> D granted next edge, pmem_write=1.
- Icache read alone, addr 0x0000_1234, adapter resp after 4 cycles with rdata=256'hA5... -> pmem_read=1, pmem_address=0x0000_1220; i_pmem_resp=1 for exactly 1 cycle with i_pmem_rdata=256'hA5...; d_pmem_resp stays 0.
- Dcache writeback, addr 0x8000_0040, wdata=256'h1 -> pmem_write=1 with pmem_wdata=256'h1 held until resp; d_pmem_resp one cycle; then DONE with all outputs 0.
- Simultaneous I read and D read after reset -> grant order D, I, D, I across 4 transactions; pmem_address matches each owner.
- D changes d_pmem_address from 0x100 to 0x200 mid-BUSY -> pmem_address stays 0x100 until resp.
- rst=0 during BUSY before pmem_resp -> next cycle pmem_read=0, no resp to either cache; afterwards a new I request is granted normally.

Source files
------------

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one cacheline adapter between icache and dcache
// Requests are latched at grant so the adapter sees a stable op until it responds.
module cache_arbiter #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_addr   = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [s_addr-1:0] i_pmem_address,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_addr-1:0] pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic [s_addr-1:0] LINE_MASK = {{(s_addr-s_offset){1'b1}}, {s_offset{1'b0}}};

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                op_write_q, op_write_d;
  logic [s_addr-1:0]   addr_q, addr_d;
  logic [s_line-1:0]   wdata_q, wdata_d;
  logic                last_grant_q, last_grant_d;

  logic                i_req;
  logic                d_req;
  logic                grant_side;
  logic [s_addr-1:0]   grant_addr;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // D wins when it is the only requester, or on contention when I was served last.
  assign grant_side = d_req & (~i_req | (last_grant_q == OWN_I));
  assign grant_addr = grant_side ? d_pmem_address : i_pmem_address;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= OWN_I;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          state_d      = BUSY;
          owner_d      = grant_side;
          last_grant_d = grant_side;
          addr_d       = grant_addr & LINE_MASK;
          if (grant_side == OWN_D) begin
            op_write_d = d_pmem_write;
            wdata_d    = d_pmem_wdata;
          end else begin
            op_write_d = 1'b0;
          end
        end
      end
      BUSY: begin
        if (pmem_resp) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    if (state_q == BUSY) begin
      pmem_read    = ~op_write_q;
      pmem_write   = op_write_q;
      pmem_address = addr_q;
      pmem_wdata   = wdata_q;
      i_pmem_resp  = pmem_resp & (owner_q == OWN_I);
      d_pmem_resp  = pmem_resp & (owner_q == OWN_D);
    end
  end

  // Fill data is broadcast; only the owner's resp cycle qualifies it.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed and randomized scoreboard bench for cache_arbiter
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  cache_arbiter #(.s_offset(5), .s_line(256), .s_addr(32)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
    int unsigned  cyc;
  } req_t;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  bit          mon_en = 0;
  bit          adp_en = 0;
  req_t        exp_i[$];
  req_t        exp_d[$];

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pmem_read"}, 256'(pmem_read), 256'(0));
    chk({tag, "_pmem_write"}, 256'(pmem_write), 256'(0));
    chk({tag, "_pmem_address"}, 256'(pmem_address), 256'(0));
    chk({tag, "_pmem_wdata"}, pmem_wdata, 256'(0));
    chk({tag, "_i_resp"}, 256'(i_pmem_resp), 256'(0));
    chk({tag, "_d_resp"}, 256'(d_pmem_resp), 256'(0));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Adapter model: responds a random number of cycles after an op appears.
  initial begin
    int cnt = 0;
    int dly = 0;
    forever begin
      tick();
      if (adp_en) begin
        pmem_resp = 1'b0;
        if (pmem_read || pmem_write) begin
          if (cnt >= dly) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rand256();
            cnt = 0;
            dly = $urandom_range(0, 4);
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Monitor: reference arbitration is "oldest eligible requesters, alternate on contention".
  initial begin
    bit   in_op = 0;
    bit   side = 0;
    bit   model_last = 0;
    bit   ie, de;
    req_t cur;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!in_op && (pmem_read || pmem_write)) begin
          ie = (exp_i.size() > 0) && (exp_i[0].cyc < cyc);
          de = (exp_d.size() > 0) && (exp_d[0].cyc < cyc);
          if (!ie && !de) begin
            chk("spurious_grant", 256'(1), 256'(0));
          end else begin
            side = (ie && de) ? ~model_last : de;
            cur = side ? exp_d[0] : exp_i[0];
            model_last = side;
            in_op = 1;
          end
        end
        if (in_op) begin
          chk(side ? "d_op_address" : "i_op_address", 256'(pmem_address), 256'(cur.addr));
          chk("op_write", 256'(pmem_write), 256'(cur.wr));
          chk("op_read", 256'(pmem_read), 256'(!cur.wr));
          if (cur.wr) chk("op_wdata", pmem_wdata, cur.wdata);
          if (pmem_resp) begin
            chk("resp_i", 256'(i_pmem_resp), 256'(side == 0));
            chk("resp_d", 256'(d_pmem_resp), 256'(side == 1));
            if (side) begin
              if (!cur.wr) chk("d_rdata", d_pmem_rdata, pmem_rdata);
              void'(exp_d.pop_front());
            end else begin
              chk("i_rdata", i_pmem_rdata, pmem_rdata);
              void'(exp_i.pop_front());
            end
            in_op = 0;
          end else begin
            chk("early_resp", 256'({i_pmem_resp, d_pmem_resp}), 256'(0));
          end
        end else begin
          chk_quiet("idle");
        end
      end
    end
  end

  task automatic drive_i(input int n);
    bit got;
    req_t r;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      r.addr = $urandom;
      i_pmem_address = r.addr;
      r.addr[4:0] = 5'd0;
      r.wr = 1'b0;
      r.wdata = '0;
      r.cyc = cyc;
      exp_i.push_back(r);
      i_pmem_read = 1'b1;
      got = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (i_pmem_resp) begin got = 1; break; end
      end
      chk("i_resp_timeout", 256'(got), 256'(1));
      tick();
      i_pmem_read = 1'b0;
    end
  endtask

  task automatic drive_d(input int n);
    bit got;
    int op;
    req_t r;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      op = $urandom_range(0, 2);
      r.addr = $urandom;
      r.wdata = rand256();
      d_pmem_address = r.addr;
      d_pmem_wdata = r.wdata;
      r.addr[4:0] = 5'd0;
      r.wr = (op != 0);
      r.cyc = cyc;
      exp_d.push_back(r);
      d_pmem_read  = (op != 1);
      d_pmem_write = (op != 0);
      got = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (d_pmem_resp) begin got = 1; break; end
      end
      chk("d_resp_timeout", 256'(got), 256'(1));
      tick();
      d_pmem_read = 1'b0;
      d_pmem_write = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b1;
    d_pmem_address = 32'h8000_0040; d_pmem_wdata = 256'h1;
    pmem_rdata = '0; pmem_resp = 1'b0;

    // Reset held with a pending writeback, then D granted right after release.
    tick(); tick();
    @(negedge clk); chk_quiet("reset");
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    chk("wb_pmem_write", 256'(pmem_write), 256'(1));
    chk("wb_pmem_read", 256'(pmem_read), 256'(0));
    chk("wb_address", 256'(pmem_address), 256'(32'h8000_0040));
    chk("wb_wdata", pmem_wdata, 256'h1);
    tick(); tick();
    @(negedge clk);
    chk("wb_wdata_held", pmem_wdata, 256'h1);
    chk("wb_no_early_resp", 256'(d_pmem_resp), 256'(0));
    tick(); pmem_resp = 1'b1; pmem_rdata = rand256();
    @(negedge clk);
    chk("wb_d_resp", 256'(d_pmem_resp), 256'(1));
    chk("wb_i_resp", 256'(i_pmem_resp), 256'(0));
    chk("wb_write_thru_resp", 256'(pmem_write), 256'(1));
    tick(); pmem_resp = 1'b0; d_pmem_write = 1'b0;
    @(negedge clk); chk_quiet("wb_done");

    // Icache fill, unaligned address.
    tick(); i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1234;
    tick();
    @(negedge clk);
    chk("ird_pmem_read", 256'(pmem_read), 256'(1));
    chk("ird_pmem_write", 256'(pmem_write), 256'(0));
    chk("ird_address", 256'(pmem_address), 256'(32'h0000_1220));
    tick(); tick(); tick();
    tick(); pmem_resp = 1'b1; pmem_rdata = PAT_A5;
    @(negedge clk);
    chk("ird_i_resp", 256'(i_pmem_resp), 256'(1));
    chk("ird_rdata", i_pmem_rdata, PAT_A5);
    chk("ird_d_resp", 256'(d_pmem_resp), 256'(0));
    tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0;
    @(negedge clk);
    chk("ird_resp_one_cycle", 256'(i_pmem_resp), 256'(0));
    chk("ird_done_read", 256'(pmem_read), 256'(0));

    // Address change mid-transaction is ignored.
    tick(); d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0100;
    tick();
    tick(); d_pmem_address = 32'h0000_0200;
    @(negedge clk); chk("mid_addr_hold", 256'(pmem_address), 256'(32'h100));
    tick(); pmem_resp = 1'b1;
    @(negedge clk);
    chk("mid_addr_resp", 256'(pmem_address), 256'(32'h100));
    chk("mid_d_resp", 256'(d_pmem_resp), 256'(1));
    tick(); pmem_resp = 1'b0; d_pmem_read = 1'b0;

    // Reset during BUSY abandons the op; stray adapter resp in IDLE is dropped.
    tick(); i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0040;
    tick();
    @(negedge clk); chk("rb_pmem_read", 256'(pmem_read), 256'(1));
    tick(); rst = 1'b0;
    tick(); rst = 1'b1; pmem_resp = 1'b1;
    @(negedge clk);
    chk("rb_abandon_read", 256'(pmem_read), 256'(0));
    chk("rb_no_i_resp", 256'(i_pmem_resp), 256'(0));
    chk("rb_no_d_resp", 256'(d_pmem_resp), 256'(0));
    tick(); pmem_resp = 1'b0;
    @(negedge clk);
    chk("rb_regrant", 256'(pmem_read), 256'(1));
    chk("rb_regrant_addr", 256'(pmem_address), 256'(32'h40));
    tick(); pmem_resp = 1'b1;
    @(negedge clk); chk("rb_i_resp", 256'(i_pmem_resp), 256'(1));
    tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0;
    tick();

    // Randomized contention against the reference model.
    rst = 1'b0;
    tick(); rst = 1'b1;
    adp_en = 1; mon_en = 1;
    fork
      drive_i(30);
      drive_d(30);
    join
    repeat (4) tick();
    chk("exp_i_drained", 256'(exp_i.size()), 256'(0));
    chk("exp_d_drained", 256'(exp_d.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
